// File: rtl/demux_1x4_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1x4_stream_if
//  Purpose  : Stream bundle for the 1:4 demultiplexer: one valid/ready input
//             stream (with a 2-bit channel select) and four output channels.
//  Revision : 1.0  initial release
// ============================================================================
interface demux_1x4_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;

    // Demultiplexer side: consumes the input stream, sources the channels.
    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

    // Producer/consumer side: drives the input stream, sinks the channels.
    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/demux_1x4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1x4_stream
//  Purpose  : Registered 1-to-4 stream demultiplexer. The input word is
//             steered by in_sel into one of four one-entry output registers,
//             each with its own valid/ready handshake and a saturating
//             accepted-word counter.
//  Revision : 1.0  initial release
// ============================================================================
module demux_1x4_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    demux_1x4_stream_if.slave       bus,
    input  wire logic               cnt_clr,
    output logic [4*CNT_W-1:0]      cnt
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } chan_state_e;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [3:0]         w_valid;
    logic [3:0]         w_load;
    logic [3:0]         w_drain;
    logic [4*WIDTH-1:0] w_out_data;
    logic               w_in_ready;
    logic               w_accept;

    // Ready only looks at the targeted channel, so a blocked channel stalls
    // the input only while it is the one being addressed. A full channel that
    // drains this cycle can still take the next word (pass-through ready).
    assign w_in_ready = rst_n & (~w_valid[bus.in_sel] | bus.out_ready[bus.in_sel]);
    assign w_accept   = bus.in_valid & w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_out_data;

    for (genvar i = 0; i < 4; i++) begin : g_chan
        localparam logic [1:0] c_ch_sel = 2'(i);

        chan_state_e      r_state;
        chan_state_e      w_state_nxt;
        logic [WIDTH-1:0] r_data;
        logic [CNT_W-1:0] r_cnt;

        assign w_load[i]  = w_accept & (bus.in_sel == c_ch_sel);
        assign w_drain[i] = w_valid[i] & bus.out_ready[i];
        assign w_valid[i] = (r_state == ST_FULL);

        assign w_out_data[i*WIDTH +: WIDTH] = r_data;
        assign cnt[i*CNT_W +: CNT_W]        = r_cnt;

        // Channel occupancy: a load wins over a same-cycle drain.
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_EMPTY: if (w_load[i])                 w_state_nxt = ST_FULL;
                ST_FULL:  if (w_drain[i] && !w_load[i])  w_state_nxt = ST_EMPTY;
                default:                                 w_state_nxt = ST_EMPTY;
            endcase
        end

        // State and held word; data only changes on a load, so it is stable while stalled.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= ST_EMPTY;
                r_data  <= '0;
            end else begin
                r_state <= w_state_nxt;
                if (w_load[i]) begin
                    r_data <= bus.in_data;
                end
            end
        end

        // Saturating accepted-word counter; clear beats a same-cycle increment.
        always_ff @(posedge clk) begin
            if (!rst_n || cnt_clr) begin
                r_cnt <= '0;
            end else if (w_load[i] && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_1x4_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1x4_stream
//  Purpose  : Directed bench for demux_1x4_stream with a reference model of
//             channel occupancy and counters plus a data scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_1x4_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [1:0]       ch;
        logic [WIDTH-1:0] data;
    } sb_t;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic               cnt_clr = 1'b0;
    logic [4*CNT_W-1:0] cnt;

    demux_1x4_stream_if #(.WIDTH(WIDTH)) bus ();

    demux_1x4_stream #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cnt_clr (cnt_clr),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    sb_t              sb_q [$];
    logic [3:0]       m_valid;
    logic [CNT_W-1:0] m_cnt [4];
    int               n_vec;
    int               n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check at the falling edge, advance model.
    task automatic step(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d,
                        input logic [3:0] rdy, input logic clr);
        logic exp_rdy;
        logic acc;
        int   idx;
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_data   = d;
        bus.out_ready = rdy;
        cnt_clr       = clr;
        @(negedge clk);
        exp_rdy = rst_n & (~m_valid[sel] | rdy[sel]);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cnt%0d", i), 32'(cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
        end
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i]) begin
                idx = -1;
                for (int k = 0; k < sb_q.size(); k++) begin
                    if (idx < 0 && sb_q[k].ch == 2'(i)) idx = k;
                end
                if (idx < 0) begin
                    chk($sformatf("sb_entry_ch%0d", i), 32'(0), 32'(1));
                end else begin
                    chk($sformatf("data_ch%0d", i), 32'(bus.out_data[i*WIDTH +: WIDTH]),
                        32'(sb_q[idx].data));
                    if (rst_n && rdy[i]) sb_q.delete(idx);
                end
            end
        end
        acc = v & exp_rdy;
        if (!rst_n) begin
            m_valid = '0;
            for (int i = 0; i < 4; i++) m_cnt[i] = '0;
            sb_q.delete();
        end else begin
            m_valid = m_valid & ~rdy;
            if (acc) begin
                m_valid[sel] = 1'b1;
                sb_q.push_back({sel, d});
            end
            if (clr) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = '0;
            end else if (acc && m_cnt[sel] != '1) begin
                m_cnt[sel] = m_cnt[sel] + 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_valid = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = '0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 4'h0;

        // Reset state
        rst_n = 1'b0;
        step(1'b1, 2'd0, 8'hEE, 4'hF, 1'b0);
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_cnt", 32'(cnt), 32'h0);
        rst_n = 1'b1;

        // Single word to ch2
        step(1'b1, 2'd2, 8'hA5, 4'hF, 1'b0);
        chk("t1_out_valid", 32'(bus.out_valid), 32'h4);
        chk("t1_ch2_data", 32'(bus.out_data[23:16]), 32'hA5);
        chk("t1_other_data", 32'({bus.out_data[31:24], bus.out_data[15:0]}), 32'h0);
        chk("t1_cnt2", 32'(cnt[11:8]), 32'h1);
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);

        // Back-pressure on ch1, then pass-through accept
        step(1'b1, 2'd1, 8'h11, 4'b1101, 1'b0);
        step(1'b1, 2'd1, 8'h22, 4'b1101, 1'b0);
        chk("t2_ch1_hold", 32'(bus.out_data[15:8]), 32'h11);
        step(1'b1, 2'd1, 8'h22, 4'b1111, 1'b0);
        chk("t2_ch1_new", 32'(bus.out_data[15:8]), 32'h22);

        // ch1 blocked, ch3 still accepts
        step(1'b1, 2'd3, 8'h33, 4'b1101, 1'b0);
        chk("t3_ch1_kept", 32'(bus.out_data[15:8]), 32'h22);
        chk("t3_ch3_data", 32'(bus.out_data[31:24]), 32'h33);
        chk("t3_out_valid", 32'(bus.out_valid), 32'hA);
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);

        // Round-robin stream, no stalls
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b1, 2'(k % 4), 8'(k), 4'hF, 1'b0);
        chk("t4_cnt", 32'(cnt), 32'h2233);
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);

        // Saturation, then clear beating an increment
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b1);
        for (int k = 0; k < 20; k++) step(1'b1, 2'd0, 8'(8'h40 + k), 4'hF, 1'b0);
        chk("t5_cnt0_sat", 32'(cnt[3:0]), 32'hF);
        step(1'b1, 2'd0, 8'h77, 4'hF, 1'b1);
        chk("t5_cnt0_clr", 32'(cnt[3:0]), 32'h0);
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);

        // Fill every channel, then a one-cycle reset discards them
        step(1'b1, 2'd0, 8'hC0, 4'h0, 1'b0);
        step(1'b1, 2'd1, 8'hC1, 4'h0, 1'b0);
        step(1'b1, 2'd2, 8'hC2, 4'h0, 1'b0);
        step(1'b1, 2'd3, 8'hC3, 4'h0, 1'b0);
        chk("t6_full", 32'(bus.out_valid), 32'hF);
        rst_n = 1'b0;
        step(1'b1, 2'd0, 8'h99, 4'h0, 1'b0);
        rst_n = 1'b1;
        chk("t6_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("t6_rst_cnt", 32'(cnt), 32'h0);
        step(1'b1, 2'd0, 8'h5A, 4'hF, 1'b0);
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
